// File: rtl/riscv32_icache_pkg.sv
// Shared types and default geometry for the direct-mapped instruction cache.
package riscv32_icache_pkg;

   typedef enum logic {
      IDLE   = 1'b0,
      REFILL = 1'b1
   } state_t;

   localparam int unsigned DEF_NUM_LINES      = 16;
   localparam int unsigned DEF_WORDS_PER_LINE = 4;

   // Clears the in-line byte offset, leaving the line base address.
   function automatic logic [31:0] line_mask(input int unsigned words);
      return ~(32'(words * 4) - 32'd1);
   endfunction

endpackage

// File: rtl/riscv32_icache_if.sv
// Fetch port, refill memory port and perf counters of riscv32_icache.
interface riscv32_icache_if;
   logic        icache_go;
   logic        icache_flush;
   logic        i_cache_rden;
   logic [31:0] i_cache_rdaddr;
   logic        i_cache_rdhit;
   logic [31:0] i_cache_rddata;
   logic        mem_rden;
   logic [31:0] mem_rdaddr;
   logic        mem_rdvalid;
   logic [31:0] mem_rddata;
   logic [31:0] hit_cnt;
   logic [31:0] miss_cnt;

   modport master (
      output icache_go, icache_flush, i_cache_rden, i_cache_rdaddr, mem_rdvalid, mem_rddata,
      input  i_cache_rdhit, i_cache_rddata, mem_rden, mem_rdaddr, hit_cnt, miss_cnt
   );

   modport slave (
      input  icache_go, icache_flush, i_cache_rden, i_cache_rdaddr, mem_rdvalid, mem_rddata,
      output i_cache_rdhit, i_cache_rddata, mem_rden, mem_rdaddr, hit_cnt, miss_cnt
   );
endinterface

// File: rtl/riscv32_icache_refill.sv
// Line refill engine: IDLE/REFILL FSM, beat counter and memory word handshake.
module riscv32_icache_refill
   import riscv32_icache_pkg::*;
#(
   parameter int unsigned WORDS_PER_LINE = DEF_WORDS_PER_LINE
) (
   input  logic                              clk,
   input  logic                              rstn,
   input  logic                              go,
   input  logic                              flush,
   input  logic                              rden,
   input  logic                              lookup_hit,
   input  logic [31:0]                       rdaddr,
   input  logic                              mem_rdvalid,
   output logic                              busy,
   output logic                              start_c,
   output logic                              accept_c,
   output logic                              fill_done_c,
   output logic [$clog2(WORDS_PER_LINE)-1:0] beat,
   output logic [31:0]                       line_base,
   output logic                              mem_rden,
   output logic [31:0]                       mem_rdaddr
);

   localparam int unsigned OFS_W = $clog2(WORDS_PER_LINE);
   localparam logic [OFS_W-1:0] LAST_BEAT = OFS_W'(WORDS_PER_LINE - 1);
   localparam logic [31:0] LINE_MASK = line_mask(WORDS_PER_LINE);

   state_t state;
   logic   cancelled;

   assign busy     = (state == REFILL);
   assign mem_rden = busy;
   assign start_c  = ~busy & rden & go & ~lookup_hit & ~flush;
   assign accept_c = mem_rden & mem_rdvalid;
   // A flush seen at any point of the refill keeps the new line invalid.
   assign fill_done_c = accept_c & (beat == LAST_BEAT) & ~cancelled & ~flush;

   always_ff @(posedge clk) begin
      if (!rstn) begin
         state      <= IDLE;
         beat       <= '0;
         cancelled  <= 1'b0;
         line_base  <= '0;
         mem_rdaddr <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (start_c) begin
                  state      <= REFILL;
                  beat       <= '0;
                  cancelled  <= 1'b0;
                  line_base  <= rdaddr & LINE_MASK;
                  mem_rdaddr <= rdaddr & LINE_MASK;
               end
            end
            REFILL: begin
               if (flush) cancelled <= 1'b1;
               if (accept_c) begin
                  if (beat == LAST_BEAT) begin
                     state      <= IDLE;
                     beat       <= '0;
                     mem_rdaddr <= '0;
                  end else begin
                     beat       <= beat + OFS_W'(1);
                     mem_rdaddr <= mem_rdaddr + 32'd4;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: rtl/riscv32_icache.sv
// Direct-mapped instruction cache with 0-cycle lookup and word-by-word refill.
// Optional perf counters enabled by defining RISCV32_ICACHE_PERF_CNT_EN.
module riscv32_icache
   import riscv32_icache_pkg::*;
#(
   parameter int unsigned NUM_LINES      = DEF_NUM_LINES,
   parameter int unsigned WORDS_PER_LINE = DEF_WORDS_PER_LINE
) (
   input logic             clk,
   input logic             rstn,
   riscv32_icache_if.slave bus
);

   localparam int unsigned IDX_W   = $clog2(NUM_LINES);
   localparam int unsigned OFS_W   = $clog2(WORDS_PER_LINE);
   localparam int unsigned TAG_LSB = IDX_W + OFS_W + 2;
   localparam int unsigned TAG_W   = 32 - TAG_LSB;

   logic [TAG_W-1:0] tag_mem  [NUM_LINES];
   logic [31:0]      data_mem [NUM_LINES * WORDS_PER_LINE];
   logic [NUM_LINES-1:0] valid;

   logic [IDX_W-1:0] idx, fill_idx;
   logic [OFS_W-1:0] ofs, beat;
   logic [TAG_W-1:0] tag, fill_tag;
   logic [31:0]      line_base;
   logic             lookup_hit, busy, start_c, accept_c, fill_done_c;
   logic             unused_base_bits;

   assign idx = bus.i_cache_rdaddr[TAG_LSB-1:OFS_W+2];
   assign ofs = bus.i_cache_rdaddr[OFS_W+1:2];
   assign tag = bus.i_cache_rdaddr[31:TAG_LSB];

   assign fill_idx         = line_base[TAG_LSB-1:OFS_W+2];
   assign fill_tag         = line_base[31:TAG_LSB];
   assign unused_base_bits = ^line_base[OFS_W+1:0];

   assign lookup_hit         = valid[idx] && (tag_mem[idx] == tag);
   assign bus.i_cache_rdhit  = bus.i_cache_rden & ~busy & lookup_hit;
   assign bus.i_cache_rddata = data_mem[{idx, ofs}];

   riscv32_icache_refill #(
      .WORDS_PER_LINE(WORDS_PER_LINE)
   ) u_refill (
      .clk        (clk),
      .rstn       (rstn),
      .go         (bus.icache_go),
      .flush      (bus.icache_flush),
      .rden       (bus.i_cache_rden),
      .lookup_hit (lookup_hit),
      .rdaddr     (bus.i_cache_rdaddr),
      .mem_rdvalid(bus.mem_rdvalid),
      .busy       (busy),
      .start_c    (start_c),
      .accept_c   (accept_c),
      .fill_done_c(fill_done_c),
      .beat       (beat),
      .line_base  (line_base),
      .mem_rden   (bus.mem_rden),
      .mem_rdaddr (bus.mem_rdaddr)
   );

   // Storage arrays carry no reset; valid bits alone qualify their contents.
   always_ff @(posedge clk) begin
      if (accept_c) data_mem[{fill_idx, beat}] <= bus.mem_rddata;
      if (fill_done_c) tag_mem[fill_idx] <= fill_tag;
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         valid <= '0;
      end else if (bus.icache_flush) begin
         valid <= '0;
      end else if (fill_done_c) begin
         valid[fill_idx] <= 1'b1;
      end
   end

`ifdef RISCV32_ICACHE_PERF_CNT_EN
   logic [31:0] hit_q, miss_q;

   always_ff @(posedge clk) begin
      if (!rstn) begin
         hit_q  <= '0;
         miss_q <= '0;
      end else begin
         if (bus.i_cache_rdhit && (hit_q != '1)) hit_q <= hit_q + 32'd1;
         if (start_c && (miss_q != '1)) miss_q <= miss_q + 32'd1;
      end
   end

   assign bus.hit_cnt  = hit_q;
   assign bus.miss_cnt = miss_q;
`else
   assign bus.hit_cnt  = '0;
   assign bus.miss_cnt = '0;
`endif

endmodule
